// File: rtl/cve2_obi_pkg.sv
// Shared types and limits for the OBI RAM responder.
package cve2_obi_pkg;

    localparam int OBI_MAX_RESP_LATENCY = 4;

    // One slot of the response pipeline.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic        is_read;
        logic [31:0] rdata;
    } obi_resp_stage_t;

endpackage

// File: rtl/cve2_obi_ram_mem.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enable and
// registered read data. Drop-in point for an SRAM macro wrapper.
module cve2_obi_ram_mem #(
    parameter int  MEM_WORDS = 1024,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    // Byte-masked write or word read; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_i[k]) begin
                        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/cve2_obi_ram_responder.sv
// OBI-style bus responder: grants requests, accesses an internal RAM and
// returns in-order responses after a fixed latency. Grants stop during a
// core clear while in-flight responses still drain.
module cve2_obi_ram_responder
    import cve2_obi_pkg::*;
#(
    parameter int          MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_n,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

    logic            clear_q;
    logic            accept;
    logic [31:0]     off;
    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic [31:0]     mem_rdata;
    logic [31:0]     last_rdata;
    obi_resp_stage_t stage_q [1:RESP_LATENCY];
    obi_resp_stage_t last;
    logic            unused_off;

    // Grant is combinational from req_i; reset gates it immediately.
    assign gnt_o  = req_i & clear_q & rst_ni;
    assign accept = req_i & gnt_o;

    assign off        = addr_i - BASE_ADDR;
    assign in_range   = (addr_i >= BASE_ADDR) && (off < SPAN);
    assign word_idx   = off[AW+1:2];
    assign unused_off = ^{off[31:AW+2], off[1:0]};

    cve2_obi_ram_mem #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk_i   (clk_i),
        .req_i   (accept & in_range),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (word_idx),
        .wdata_i (wdata_i),
        .rdata_o (mem_rdata)
    );

    // clear_n is sampled once; reset forces grants off until it is seen high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clear_q <= 1'b0;
        end else begin
            clear_q <= clear_n;
        end
    end

    // Response pipeline: stage 1 tracks the accept, read data joins at stage 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 1; s <= RESP_LATENCY; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[1] <= '{valid:   accept,
                            err:     accept & ~in_range,
                            is_read: ~we_i,
                            rdata:   32'h0};
            for (int s = 2; s <= RESP_LATENCY; s++) begin
                stage_q[s] <= '{valid:   stage_q[s-1].valid,
                                err:     stage_q[s-1].err,
                                is_read: stage_q[s-1].is_read,
                                rdata:   (s == 2) ? mem_rdata : stage_q[s-1].rdata};
            end
        end
    end

    generate
        if (RESP_LATENCY == 1) begin : g_lat1
            assign last_rdata = mem_rdata;
        end else begin : g_latn
            assign last_rdata = stage_q[RESP_LATENCY].rdata;
        end
    endgenerate

    assign last     = stage_q[RESP_LATENCY];
    assign rvalid_o = last.valid;
    assign err_o    = last.valid & last.err;
    assign rdata_o  = (last.valid & last.is_read & ~last.err) ? last_rdata : 32'h0;

    // Busy while any stage still holds an unanswered transfer.
    always_comb begin
        busy_o = 1'b0;
        for (int s = 1; s <= RESP_LATENCY; s++) begin
            busy_o = busy_o | stage_q[s].valid;
        end
    end

endmodule

// File: tb/tb_cve2_obi_ram_responder.sv
// Bench for cve2_obi_ram_responder: two instances (latency 1 and 3) share
// stimulus and are compared every cycle against a transaction-level model.
module tb_cve2_obi_ram_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] SPAN = 32'(4 * MW);

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        clear_n;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;

    logic        gnt_a, rvalid_a, err_a, busy_a;
    logic [31:0] rdata_a;
    logic        gnt_b, rvalid_b, err_b, busy_b;
    logic [31:0] rdata_b;
    logic [35:0] act_a, act_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    cve2_obi_ram_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .RESP_LATENCY(1)) u_dut_l1 (
        .clk_i(clk_i), .rst_ni(rst_n), .clear_n(clear_n), .req_i(req_i), .gnt_o(gnt_a),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a), .busy_o(busy_a));

    cve2_obi_ram_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .RESP_LATENCY(3)) u_dut_l3 (
        .clk_i(clk_i), .rst_ni(rst_n), .clear_n(clear_n), .req_i(req_i), .gnt_o(gnt_b),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b), .busy_o(busy_b));

    assign act_a = {gnt_a, rvalid_a, err_a, busy_a, rdata_a};
    assign act_b = {gnt_b, rvalid_b, err_b, busy_b, rdata_b};

    // ---------------- reference model ----------------
    // Each accepted transfer becomes a queued response due at a given edge.
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mmem [MW];
    int          edge_n = 0;
    logic        clq = 1'b0;

    always @(posedge clk_i or negedge rst_n) begin : model
        exp_t r;
        logic ok;
        int   idx;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            clq = 1'b0;
        end else begin
            edge_n++;
            while (qa.size() > 0 && qa[0].due < edge_n) void'(qa.pop_front());
            while (qb.size() > 0 && qb[0].due < edge_n) void'(qb.pop_front());
            if (req_i && clq) begin
                ok     = (addr_i >= BASE) && (addr_i < BASE + SPAN);
                r.err  = !ok;
                r.data = 32'h0;
                if (ok) begin
                    idx = int'((addr_i - BASE) >> 2);
                    if (we_i) begin
                        for (int k = 0; k < 4; k++)
                            if (be_i[k]) mmem[idx][8*k +: 8] = wdata_i[8*k +: 8];
                    end else begin
                        r.data = mmem[idx];
                    end
                end
                r.due = edge_n;
                qa.push_back(r);
                r.due = edge_n + 2;
                qb.push_back(r);
            end
            clq = clear_n;
        end
    end

    // Expected {gnt, rvalid, err, busy, rdata} for the current cycle.
    function automatic logic [35:0] exp_out(input bit slow);
        exp_t        f;
        bit          have;
        logic        v = 1'b0;
        logic        e = 1'b0;
        logic [31:0] d = 32'h0;
        if (slow) begin
            have = qb.size() > 0;
            if (have) f = qb[0];
        end else begin
            have = qa.size() > 0;
            if (have) f = qa[0];
        end
        if (have && f.due == edge_n) begin
            v = 1'b1;
            e = f.err;
            d = f.data;
        end
        return {req_i & clq & rst_n, v, e, logic'(have), d};
    endfunction

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        be_i    = b;
        wdata_i = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first = -1;
        rst_n   = 1'b0;
        clear_n = 1'b0;
        drive(1, 1, BASE + 32'h10, 4'hF, 32'h0);
        repeat (3) @(negedge clk_i);
        nvec++;
        if (act_a !== 36'h0 || act_b !== 36'h0) begin
            nerr++;
            $display("FAIL reset_state: l1=%h l3=%h, required 0", act_a, act_b);
        end
        rst_n   = 1'b1;
        clear_n = 1'b1;
        #1;
        nvec++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            nerr++;
            $display("FAIL reset_early_gnt: gnt l1=%b l3=%b, required 0", gnt_a, gnt_b);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL reset_cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (first < 0 && gnt_a === 1'b1) first = i;
            if (i == 0) drive(0, 0, BASE, 4'h0, 32'h0);
        end
        nvec++;
        if (first !== 0) begin
            nerr++;
            $display("FAIL reset_first_grant: cycle %0d, required 0", first);
        end
    endtask

    task automatic test_init();
        for (int i = 0; i <= MW; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL init %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (i < MW) drive(1, 1, BASE + 32'(4 * i), 4'hF, $urandom);
            else        drive(0, 0, BASE, 4'h0, 32'h0);
        end
    endtask

    task automatic test_write_read(input string nm, input logic [3:0] be,
                                   input logic [31:0] wd, input logic [31:0] req_data);
        int          ta = -1;
        int          tb = -1;
        logic [31:0] da = 32'h0;
        logic [31:0] db = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL %s cycle %0d: l1=%h exp %h l3=%h exp %h", nm, i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (i > 5 && ta < 0 && rvalid_a === 1'b1) begin ta = i - 5; da = rdata_a; end
            if (i > 5 && tb < 0 && rvalid_b === 1'b1) begin tb = i - 5; db = rdata_b; end
            if (i == 0)      drive(1, 1, BASE + 32'h10, be, wd);
            else if (i == 5) drive(1, 0, BASE + 32'h10, 4'h0, 32'h0);
            else             drive(0, 0, BASE, 4'h0, 32'h0);
        end
        nvec += 2;
        if (ta !== 1 || tb !== 3) begin
            nerr++;
            $display("FAIL %s_latency: l1=%0d l3=%0d, required 1 and 3", nm, ta, tb);
        end
        if (da !== req_data || db !== req_data) begin
            nerr++;
            $display("FAIL %s_data: l1=%h l3=%h, required %h", nm, da, db, req_data);
        end
    endtask

    task automatic test_out_of_range();
        int ea = 0;
        int eb = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL oor cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (rvalid_a === 1'b1 && err_a === 1'b1) ea++;
            if (rvalid_b === 1'b1 && err_b === 1'b1) eb++;
            case (i)
                0:       drive(1, 0, BASE + SPAN, 4'h0, 32'h0);
                1:       drive(1, 1, BASE + SPAN, 4'hF, $urandom);
                2:       drive(1, 1, BASE - 32'd4, 4'hF, $urandom);
                3:       drive(1, 0, BASE - 32'd4, 4'h0, 32'h0);
                4:       drive(1, 0, BASE, 4'h0, 32'h0);
                5:       drive(1, 0, BASE + SPAN - 32'd4, 4'h0, 32'h0);
                default: drive(0, 0, BASE, 4'h0, 32'h0);
            endcase
        end
        nvec++;
        if (ea !== 4 || eb !== 4) begin
            nerr++;
            $display("FAIL oor_err_count: l1=%0d l3=%0d, required 4", ea, eb);
        end
    endtask

    task automatic test_back_to_back();
        int st = int'($urandom_range(0, MW - 8));
        int ng = 0;
        int va = 0;
        int vb = 0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL b2b cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (gnt_a === 1'b1 && gnt_b === 1'b1) ng++;
            if (rvalid_a === 1'b1) va++;
            if (rvalid_b === 1'b1) vb++;
            if (i < 8)       drive(1, 1, BASE + 32'(4 * (st + i)), 4'hF, $urandom);
            else if (i < 16) drive(1, 0, BASE + 32'(4 * (st + i - 8)), 4'h0, 32'h0);
            else             drive(0, 0, BASE, 4'h0, 32'h0);
        end
        nvec += 2;
        if (ng !== 16) begin
            nerr++;
            $display("FAIL b2b_grants: %0d, required 16", ng);
        end
        if (va !== 16 || vb !== 16) begin
            nerr++;
            $display("FAIL b2b_responses: l1=%0d l3=%0d, required 16", va, vb);
        end
    endtask

    task automatic test_clear();
        int ng = 0;
        int vb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL clear cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (i >= 3 && i <= 8 && gnt_b === 1'b1) ng++;
            if (rvalid_b === 1'b1) vb++;
            if (i == 5) begin
                nvec++;
                if (busy_b !== 1'b1) begin
                    nerr++;
                    $display("FAIL clear_busy_last: %b, required 1", busy_b);
                end
            end
            if (i == 6) begin
                nvec++;
                if (busy_b !== 1'b0) begin
                    nerr++;
                    $display("FAIL clear_busy_drop: %b, required 0", busy_b);
                end
            end
            if (i == 2) clear_n = 1'b0;
            if (i == 8) clear_n = 1'b1;
            if (i < 8) drive(1, 0, BASE + 32'(4 * $urandom_range(0, MW - 1)), 4'h0, 32'h0);
            else       drive(0, 0, BASE, 4'h0, 32'h0);
        end
        nvec += 2;
        if (ng !== 0) begin
            nerr++;
            $display("FAIL clear_no_grant: %0d grants, required 0", ng);
        end
        if (vb !== 3) begin
            nerr++;
            $display("FAIL clear_drain: %0d responses, required 3", vb);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL random cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            case ($urandom_range(0, 7))
                0:       a = BASE + SPAN + 32'(4 * $urandom_range(0, 15));
                1:       a = BASE - 32'(4 * (1 + $urandom_range(0, 15)));
                default: a = BASE + 32'(4 * $urandom_range(0, MW - 1));
            endcase
            a = a + 32'($urandom_range(0, 3));
            clear_n = ($urandom_range(0, 19) != 0);
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), a,
                  4'($urandom_range(0, 15)), $urandom);
        end
        clear_n = 1'b1;
        drive(0, 0, BASE, 4'h0, 32'h0);
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] wd [4];
        logic [31:0] got[$];
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL rstburst cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (i < 4) drive(1, 1, BASE + 32'(4 * (20 + i)), 4'hF, wd[i]);
            else       drive(1, 0, BASE + 32'(4 * (20 + i - 4)), 4'h0, 32'h0);
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (act_a !== 36'h0 || act_b !== 36'h0) begin
            nerr++;
            $display("FAIL rstburst_immediate: l1=%h l3=%h, required 0", act_a, act_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            nvec++;
            if ({rvalid_a, busy_a, rvalid_b, busy_b} !== 4'b0000) begin
                nerr++;
                $display("FAIL rstburst_hold %0d: rv/busy=%b, required 0000", i, {rvalid_a, busy_a, rvalid_b, busy_b});
            end
        end
        rst_n = 1'b1;
        drive(0, 0, BASE, 4'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            nvec++;
            if (act_a !== exp_out(0) || act_b !== exp_out(1)) begin
                nerr++;
                $display("FAIL rstread cycle %0d: l1=%h exp %h l3=%h exp %h", i, act_a, exp_out(0), act_b, exp_out(1));
            end
            if (rvalid_a === 1'b1) got.push_back(rdata_a);
            if (i >= 1 && i <= 4) drive(1, 0, BASE + 32'(4 * (20 + i - 1)), 4'h0, 32'h0);
            else                  drive(0, 0, BASE, 4'h0, 32'h0);
        end
        nvec++;
        if (got.size() !== 4) begin
            nerr++;
            $display("FAIL rstread_count: %0d, required 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if (got[k] !== wd[k]) begin
                    nerr++;
                    $display("FAIL rstread_data %0d: %h, required %h", k, got[k], wd[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read("wr_full", 4'hF, 32'hDEADBEEF, 32'hDEADBEEF);
        test_write_read("wr_part", 4'b0101, 32'h11223344, 32'hDE22BE44);
        test_out_of_range();
        test_back_to_back();
        test_clear();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
